rob: RTL and testbench

Reorder buffer sitting directly downstream of the rename stage. It takes one renamed instruction per cycle (new physical destination plus the displaced physical mapping), hands back an in-order tag, and collects completion notices from two execution writeback ports. It retires up to two completed instructions per cycle in program order and returns the displaced physical registers to the free pool as a 64-bit one-hot free mask.

---
 rtl/rob_if.sv | 35 +++
 rtl/rob.sv | 139 +++++++++++++
 tb/tb_rob.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/rob_if.sv
// Rename / writeback / retire signal bundle for the reorder buffer.
// The slave modport is the ROB side; the master modport is the pipeline side.
interface rob_if #(
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
);
  logic              alloc_valid;
  logic [4:0]        alloc_dr;
  logic [PREG_W-1:0] alloc_dr_p;
  logic [6:0]        alloc_old_dr;
  logic              alloc_ready;
  logic [TAG_W-1:0]  alloc_tag;
  logic              cmpl0_valid, cmpl1_valid;
  logic [TAG_W-1:0]  cmpl0_tag, cmpl1_tag;
  logic [1:0]        retire_valid;
  logic [4:0]        retire_dr0, retire_dr1;
  logic [PREG_W-1:0] retire_dr_p0, retire_dr_p1;
  logic [63:0]       retire_free;
  logic [TAG_W:0]    rob_count;
  logic              rob_empty, rob_full;

  modport master (
    output alloc_valid, alloc_dr, alloc_dr_p, alloc_old_dr,
    output cmpl0_valid, cmpl0_tag, cmpl1_valid, cmpl1_tag,
    input  alloc_ready, alloc_tag, retire_valid, retire_dr0, retire_dr1,
    input  retire_dr_p0, retire_dr_p1, retire_free, rob_count, rob_empty, rob_full
  );

  modport slave (
    input  alloc_valid, alloc_dr, alloc_dr_p, alloc_old_dr,
    input  cmpl0_valid, cmpl0_tag, cmpl1_valid, cmpl1_tag,
    output alloc_ready, alloc_tag, retire_valid, retire_dr0, retire_dr1,
    output retire_dr_p0, retire_dr_p1, retire_free, rob_count, rob_empty, rob_full
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocate, two-port out-of-order completion,
// up to two in-order retirements per cycle with a one-hot physical free mask.

module rob_entry #(
  parameter int PREG_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              cmpl,
  input  logic              clr,
  input  logic [4:0]        wr_dr,
  input  logic [PREG_W-1:0] wr_dr_p,
  input  logic [6:0]        wr_old,
  output logic              valid,
  output logic              done,
  output logic [4:0]        dr,
  output logic [PREG_W-1:0] dr_p,
  output logic [6:0]        old_dr
);
  // Allocation wins over a stray completion to the same slot in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (wr) begin
      valid <= 1'b1;
      done  <= 1'b0;
    end else if (clr) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else if (cmpl && valid) begin
      done  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      dr     <= wr_dr;
      dr_p   <= wr_dr_p;
      old_dr <= wr_old;
    end
  end
endmodule

module rob #(
  parameter int DEPTH  = 16,
  parameter int TAG_W  = 4,
  parameter int PREG_W = 6
) (
  input logic clk,
  input logic rst,
  rob_if.slave bus
);
  logic [TAG_W-1:0]             head, head1, tail;
  logic [TAG_W:0]               count;
  logic                         full, alloc_go, fire0, fire1;
  logic [DEPTH-1:0]             ent_valid, ent_done, ent_wr, ent_cmpl, ent_clr;
  logic [DEPTH-1:0][4:0]        ent_dr;
  logic [DEPTH-1:0][PREG_W-1:0] ent_dr_p;
  logic [DEPTH-1:0][6:0]        ent_old;
  logic [63:0]                  free_nxt;

  // Full/empty come from the occupancy count; head==tail is ambiguous.
  assign full            = (count == (TAG_W+1)'(DEPTH));
  assign alloc_go        = bus.alloc_valid & ~full;
  assign bus.alloc_ready = ~full;
  assign bus.alloc_tag   = tail;
  assign bus.rob_count   = count;
  assign bus.rob_empty   = (count == '0);
  assign bus.rob_full    = full;

  assign head1 = head + TAG_W'(1);
  assign fire0 = ent_valid[head] & ent_done[head];
  assign fire1 = fire0 & ent_valid[head1] & ent_done[head1];

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      assign ent_wr[i]   = alloc_go && (tail == TAG_W'(i));
      assign ent_cmpl[i] = (bus.cmpl0_valid && (bus.cmpl0_tag == TAG_W'(i))) ||
                           (bus.cmpl1_valid && (bus.cmpl1_tag == TAG_W'(i)));
      assign ent_clr[i]  = (fire0 && (head == TAG_W'(i))) ||
                           (fire1 && (head1 == TAG_W'(i)));
      rob_entry #(.PREG_W(PREG_W)) u_ent (
        .clk    (clk),
        .rst    (rst),
        .wr     (ent_wr[i]),
        .cmpl   (ent_cmpl[i]),
        .clr    (ent_clr[i]),
        .wr_dr  (bus.alloc_dr),
        .wr_dr_p(bus.alloc_dr_p),
        .wr_old (bus.alloc_old_dr),
        .valid  (ent_valid[i]),
        .done   (ent_done[i]),
        .dr     (ent_dr[i]),
        .dr_p   (ent_dr_p[i]),
        .old_dr (ent_old[i])
      );
    end
  endgenerate

  // Bit 6 flags "no displaced mapping"; preg 0 is never returned to the pool.
  function automatic logic [63:0] free_bit(input logic [6:0] old);
    free_bit = '0;
    if (!old[6] && (old[5:0] != 6'd0)) free_bit[old[5:0]] = 1'b1;
  endfunction

  always_comb begin
    free_nxt = '0;
    if (fire0) free_nxt = free_nxt | free_bit(ent_old[head]);
    if (fire1) free_nxt = free_nxt | free_bit(ent_old[head1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      bus.retire_valid <= '0;
      bus.retire_dr0   <= '0;
      bus.retire_dr1   <= '0;
      bus.retire_dr_p0 <= '0;
      bus.retire_dr_p1 <= '0;
      bus.retire_free  <= '0;
    end else begin
      if (alloc_go) tail <= tail + TAG_W'(1);
      if (fire1)      head <= head + TAG_W'(2);
      else if (fire0) head <= head + TAG_W'(1);
      count <= count + (TAG_W+1)'(alloc_go) - (TAG_W+1)'(fire0) - (TAG_W+1)'(fire1);
      bus.retire_valid <= {fire1, fire0};
      bus.retire_dr0   <= fire0 ? ent_dr[head]    : '0;
      bus.retire_dr_p0 <= fire0 ? ent_dr_p[head]  : '0;
      bus.retire_dr1   <= fire1 ? ent_dr[head1]   : '0;
      bus.retire_dr_p1 <= fire1 ? ent_dr_p[head1] : '0;
      bus.retire_free  <= free_nxt;
    end
  end
endmodule

// File: tb/tb_rob.sv
// Directed + randomized bench for rob against a queue-based program-order model.
module tb_rob;
  localparam int DEPTH = 16, TAG_W = 4, PREG_W = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rob_if #(.TAG_W(TAG_W), .PREG_W(PREG_W)) bus();
  rob #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         tag;
    logic [4:0] dr;
    logic [5:0] dr_p;
    logic [6:0] old;
    bit         done;
  } ent_t;

  ent_t        q[$];
  int          mtail;
  logic [1:0]  e_rv;
  logic [4:0]  e_dr0, e_dr1;
  logic [5:0]  e_p0, e_p1;
  logic [63:0] e_free;
  int          checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] dr, input logic [5:0] dp,
                       input logic [6:0] old, input bit c0v, input int c0t,
                       input bit c1v, input int c1t);
    bus.alloc_valid  = av;
    bus.alloc_dr     = dr;
    bus.alloc_dr_p   = dp;
    bus.alloc_old_dr = old;
    bus.cmpl0_valid  = c0v;
    bus.cmpl0_tag    = TAG_W'(c0t);
    bus.cmpl1_valid  = c1v;
    bus.cmpl1_tag    = TAG_W'(c1t);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b0, 0, 1'b0, 0);
  endtask

  function automatic logic [63:0] freed(input logic [6:0] old);
    freed = '0;
    if (old < 7'd64 && old != 7'd0) freed[old] = 1'b1;
  endfunction

  // Model of one clock edge: retire from program-order head, then completions, then allocate.
  task automatic model_edge();
    int   pre;
    ent_t e;
    e_rv = '0; e_dr0 = '0; e_dr1 = '0; e_p0 = '0; e_p1 = '0; e_free = '0;
    if (rst) begin
      q.delete();
      mtail = 0;
      return;
    end
    pre = q.size();
    if (q.size() > 0 && q[0].done) begin
      e = q.pop_front();
      e_rv[0] = 1'b1; e_dr0 = e.dr; e_p0 = e.dr_p; e_free |= freed(e.old);
      if (q.size() > 0 && q[0].done) begin
        e = q.pop_front();
        e_rv[1] = 1'b1; e_dr1 = e.dr; e_p1 = e.dr_p; e_free |= freed(e.old);
      end
    end
    foreach (q[k]) begin
      if (bus.cmpl0_valid && q[k].tag == int'(bus.cmpl0_tag)) q[k].done = 1'b1;
      if (bus.cmpl1_valid && q[k].tag == int'(bus.cmpl1_tag)) q[k].done = 1'b1;
    end
    if (bus.alloc_valid && pre < DEPTH) begin
      e.tag = mtail % DEPTH; e.dr = bus.alloc_dr; e.dr_p = bus.alloc_dr_p;
      e.old = bus.alloc_old_dr; e.done = 1'b0;
      q.push_back(e);
      mtail++;
    end
  endtask

  task automatic tick();
    chk("alloc_ready", bus.alloc_ready, q.size() != DEPTH);
    chk("alloc_tag",   bus.alloc_tag,   mtail % DEPTH);
    chk("rob_count",   bus.rob_count,   q.size());
    chk("rob_empty",   bus.rob_empty,   q.size() == 0);
    chk("rob_full",    bus.rob_full,    q.size() == DEPTH);
    chk("retire_valid", bus.retire_valid, e_rv);
    chk("retire_dr0",   bus.retire_dr0,   e_dr0);
    chk("retire_dr1",   bus.retire_dr1,   e_dr1);
    chk("retire_dr_p0", bus.retire_dr_p0, e_p0);
    chk("retire_dr_p1", bus.retire_dr_p1, e_p1);
    chk("retire_free",  bus.retire_free,  e_free);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int   r, t;
    bit   av, c0v, c1v;
    int   c0t, c1t;
    logic [6:0] old;

    do_reset();
    // Single op with the reset state checked on the first tick
    drive(1'b1, 5'd5, 6'd33, 7'd5, 1'b0, 0, 1'b0, 0); tick();
    chk("t1_count", bus.rob_count, 1);
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 0, 1'b0, 0); tick();
    idle(); tick();
    chk("t1_rv",   bus.retire_valid, 2'b01);
    chk("t1_dr",   bus.retire_dr0,   5);
    chk("t1_drp",  bus.retire_dr_p0, 33);
    chk("t1_free", bus.retire_free,  64'h20);
    chk("t1_cnt0", bus.rob_count,    0);
    tick();
    chk("t1_pulse", bus.retire_valid, 2'b00);

    // Out-of-order completion
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(k + 1), 6'(k + 10), 7'(k + 20), 1'b0, 0, 1'b0, 0); tick();
    end
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 2, 1'b0, 0); tick();
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b0, 0, 1'b1, 1); tick();
    idle(); tick();
    chk("t2_hold", bus.retire_valid, 2'b00);
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 0, 1'b0, 0); tick();
    idle(); tick();
    chk("t2_rv11", bus.retire_valid, 2'b11);
    chk("t2_dr1",  bus.retire_dr1,   2);
    tick();
    chk("t2_rv01", bus.retire_valid, 2'b01);
    chk("t2_dr0",  bus.retire_dr0,   3);

    // Full, ignored 17th alloc, wrap of the tail
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      drive(1'b1, 5'($urandom), 6'($urandom), 7'($urandom_range(0, 64)), 1'b0, 0, 1'b0, 0);
      tick();
    end
    chk("t3_full",  bus.rob_full,    1);
    chk("t3_ready", bus.alloc_ready, 0);
    chk("t3_count", bus.rob_count,   16);
    drive(1'b1, 5'd31, 6'd63, 7'd9, 1'b0, 0, 1'b0, 0); tick();
    chk("t3_still16", bus.rob_count, 16);
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 0, 1'b0, 0); tick();
    chk("t3_noroom", bus.alloc_ready, 0);
    idle(); tick();
    chk("t3_ready1", bus.alloc_ready, 1);
    chk("t3_tagwrap", bus.alloc_tag, 0);

    // Nothing freed for old_dr=64 or old_dr=0; both ports in one cycle
    do_reset();
    drive(1'b1, 5'd7, 6'd40, 7'd64, 1'b0, 0, 1'b0, 0); tick();
    drive(1'b1, 5'd8, 6'd41, 7'd0,  1'b0, 0, 1'b0, 0); tick();
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 0, 1'b1, 1); tick();
    idle(); tick();
    chk("t4_rv",   bus.retire_valid, 2'b11);
    chk("t4_free", bus.retire_free,  64'h0);
    chk("t4_drp1", bus.retire_dr_p1, 41);

    // Random traffic with wrap-around
    for (int n = 0; n < 400; n++) begin
      av  = ($urandom_range(0, 99) < 55);
      r   = $urandom_range(0, 9);
      old = (r == 0) ? 7'd64 : (r == 1) ? 7'd0 : 7'($urandom_range(1, 63));
      c0v = 1'b0; c1v = 1'b0; c0t = 0; c1t = 0;
      if (q.size() > 0 && $urandom_range(0, 99) < 60) begin
        c0v = 1'b1; c0t = q[$urandom_range(0, q.size() - 1)].tag;
      end
      if ($urandom_range(0, 99) < 40) begin
        c1v = 1'b1;
        if (q.size() > 0 && $urandom_range(0, 3) != 0) c1t = q[$urandom_range(0, q.size() - 1)].tag;
        else c1t = $urandom_range(0, DEPTH - 1);
      end
      drive(av, 5'($urandom), 6'($urandom), old, c0v, c0t, c1v, c1t);
      tick();
      chk("rnd_le16", bus.rob_count <= 5'd16, 1);
    end
    idle();
    for (int n = 0; n < 40; n++) begin
      if (q.size() > 0) begin
        t = q[0].tag;
        drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, t, 1'b0, 0);
      end else idle();
      tick();
    end

    // Reset mid-stream: 5 in flight, 2 done but blocked behind an undone head
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 5'(k), 6'(k + 1), 7'(k + 2), 1'b0, 0, 1'b0, 0); tick();
    end
    drive(1'b0, 5'd0, 6'd0, 7'd64, 1'b1, 3, 1'b1, 4); tick();
    chk("t6_count5", bus.rob_count, 5);
    rst = 1'b1; idle(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("t6_count0", bus.rob_count,    0);
    chk("t6_norv",   bus.retire_valid, 2'b00);
    chk("t6_tag0",   bus.alloc_tag,    0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
